// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int N_ROW = 4;
  localparam int N_COL = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_e;

endpackage

// File: rtl/keypad_col_scanner.sv
// Column drive, row sampling and per-frame hit accumulation for the keypad matrix.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_ROW-1:0] row_i,
  output logic [N_COL-1:0] col_o,
  output logic             frame_end_o,
  output logic             frame_tick_o,
  output frame_res_e       frame_res_o,
  output logic [KEY_W-1:0] frame_code_o
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [N_COL-1:0] col_q, col_d;
  logic [1:0]       hits_q, hits_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             tick_q;

  logic             sample;
  logic             last_col;
  logic             found;
  logic [1:0]       first_row;
  logic [2:0]       n_low;
  logic [2:0]       total;
  logic [1:0]       hits_sum;
  logic [KEY_W-1:0] code_sum;

  always_comb begin
    sample    = (dwell_q == DW_LAST);
    last_col  = (col_idx_q == 2'd3);
    found     = 1'b0;
    first_row = 2'd0;
    n_low     = 3'd0;
    for (int r = 0; r < N_ROW; r++) begin
      if (!row_i[r]) begin
        if (!found) begin
          first_row = 2'(r);
          found     = 1'b1;
        end
        n_low = n_low + 3'd1;
      end
    end
    // Hit count saturates at 2; only the first hit of the frame sets the code.
    total    = {1'b0, hits_q} + n_low;
    hits_sum = (total >= 3'd2) ? 2'd2 : total[1:0];
    code_sum = (hits_q == 2'd0 && found) ? {col_idx_q, first_row} : code_q;

    dwell_d   = sample ? '0 : dwell_q + DW_W'(1);
    col_idx_d = col_idx_q;
    col_d     = col_q;
    hits_d    = hits_q;
    code_d    = code_q;
    if (sample) begin
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(N_COL'(1) << col_idx_d);
      if (last_col) begin
        hits_d = 2'd0;
        code_d = '0;
      end else begin
        hits_d = hits_sum;
        code_d = code_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dwell_q   <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      hits_q    <= 2'd0;
      code_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      hits_q    <= hits_d;
      code_q    <= code_d;
      tick_q    <= sample && last_col;
    end
  end

  assign col_o        = col_q;
  assign frame_tick_o = tick_q;
  assign frame_end_o  = sample && last_col;
  assign frame_code_o = code_sum;
  assign frame_res_o  = (hits_sum == 2'd0) ? NONE :
                        (hits_sum == 2'd1) ? SINGLE : MULTI;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: frame-level press/release debounce FSM over the column scanner.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL           = 2,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int RELEASE_FRAMES  = 3
) (
  input  logic             clk_1kHz,
  input  logic             rst_n,
  input  logic [N_ROW-1:0] row_in,
  output logic [N_COL-1:0] col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             frame_tick
);

  localparam int DC_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RC_W = $clog2(RELEASE_FRAMES + 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RELEASE_FRAMES - 1);

  logic             frame_end;
  frame_res_e       frame_res;
  logic [KEY_W-1:0] frame_code;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  keypad_col_scanner #(
    .DWELL (DWELL)
  ) u_scan (
    .clk_i        (clk_1kHz),
    .rst_ni       (rst_n),
    .row_i        (row_in),
    .col_o        (col_out),
    .frame_end_o  (frame_end),
    .frame_tick_o (frame_tick),
    .frame_res_o  (frame_res),
    .frame_code_o (frame_code)
  );

  // The FSM steps on the column-3 sample edge so its outputs line up with frame_tick.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    dcnt_d      = dcnt_q;
    rcnt_d      = rcnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (frame_res == SINGLE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d     = PRESSED;
              key_code_d  = frame_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cand_d  = frame_code;
              dcnt_d  = DC_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (frame_res == SINGLE && frame_code == cand_q) begin
            if (dcnt_q >= DC_LAST) begin
              state_d     = PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              dcnt_d      = '0;
            end else begin
              dcnt_d = dcnt_q + DC_W'(1);
            end
          end else if (frame_res == SINGLE) begin
            cand_d = frame_code;
            dcnt_d = DC_W'(1);
          end else begin
            state_d = IDLE;
            dcnt_d  = '0;
          end
        end
        PRESSED: begin
          if (frame_res == NONE) begin
            if (RELEASE_FRAMES == 1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASE;
              rcnt_d  = RC_W'(1);
            end
          end
        end
        RELEASE: begin
          if (frame_res == NONE) begin
            if (rcnt_q >= RC_LAST) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
              rcnt_d     = '0;
            end else begin
              rcnt_d = rcnt_q + RC_W'(1);
            end
          end else begin
            // Bounce while letting go: back to held without a new press pulse.
            state_d = PRESSED;
            rcnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      dcnt_q      <= '0;
      rcnt_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      dcnt_q      <= dcnt_d;
      rcnt_q      <= rcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix plus a frame-history reference model.
module tb_keypad_scanner;

  localparam int DWELL = 2;
  localparam int DEB   = 3;
  localparam int REL   = 3;
  localparam int FRAME = 4 * DWELL;

  logic       clk_1kHz = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       frame_tick;

  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  int         hk[$];
  int         hc[$];
  logic       m_valid;
  logic       m_held;
  logic [3:0] m_code;

  logic       o_tick, o_valid, o_held;
  logic [3:0] o_code;
  int         stray;

  keypad_scanner #(
    .DWELL           (DWELL),
    .DEBOUNCE_FRAMES (DEB),
    .RELEASE_FRAMES  (REL)
  ) dut (
    .clk_1kHz   (clk_1kHz),
    .rst_n      (rst_n),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .frame_tick (frame_tick)
  );

  always #5 clk_1kHz = ~clk_1kHz;
  always @(posedge clk_1kHz) cyc++;

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (!col_out[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row_in[r] = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    hk.delete();
    hc.delete();
    m_valid = 1'b0;
    m_held  = 1'b0;
    m_code  = 4'd0;
  endtask

  // Press accepted when the last DEB frames all saw the same lone key and nothing is held;
  // release accepted when something is held and the last REL frames saw no key at all.
  task automatic model_frame(input logic [15:0] k);
    int n, kind, code;
    bit ok;
    n    = $countones(k);
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    code = 0;
    for (int i = 15; i >= 0; i--) if (k[i]) code = i;
    hk.push_back(kind);
    hc.push_back(code);
    m_valid = 1'b0;
    if (!m_held) begin
      if (hk.size() >= DEB) begin
        ok = 1'b1;
        for (int i = hk.size() - DEB; i < hk.size(); i++)
          if (hk[i] != 1 || hc[i] != code) ok = 1'b0;
        if (ok) begin
          m_valid = 1'b1;
          m_held  = 1'b1;
          m_code  = 4'(code);
        end
      end
    end else if (hk.size() >= REL) begin
      ok = 1'b1;
      for (int i = hk.size() - REL; i < hk.size(); i++)
        if (hk[i] != 0) ok = 1'b0;
      if (ok) m_held = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_1kHz);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    model_clear();
  endtask

  // Holds one key pattern for a whole frame and records what the DUT showed.
  task automatic run_frame(input logic [15:0] k);
    keys  = k;
    stray = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      @(posedge clk_1kHz); #1;
      if (key_valid !== 1'b0 || frame_tick !== 1'b0 || key_held !== m_held) stray++;
    end
    @(posedge clk_1kHz); #1;
    o_tick  = frame_tick;
    o_valid = key_valid;
    o_held  = key_held;
    o_code  = key_code;
    model_frame(k);
  endtask

  task automatic test_single_press();
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      run_frame(16'h0200);
      checks++;
      if ({o_tick, o_valid, o_held, o_code} !== {1'b1, m_valid, m_held, m_code}) begin
        errors++;
        $display("FAIL single f%0d tick/valid/held/code got %b/%b/%b/%0d want 1/%b/%b/%0d",
                 f, o_tick, o_valid, o_held, o_code, m_valid, m_held, m_code);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL single_mid f%0d stray got %0d want 0", f, stray);
      end
      if (f == 3) begin
        checks++;
        if (o_valid !== 1'b1 || o_code !== 4'd9 || (cyc - rel_cyc) != 24) begin
          errors++;
          $display("FAIL single_latency valid/code/cycle got %b/%0d/%0d want 1/9/24",
                   o_valid, o_code, cyc - rel_cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    repeat (3) @(posedge clk_1kHz);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110) begin
      errors++;
      $display("FAIL reset_col got %b want 1110", col_out);
    end
    checks++;
    if ({key_code, key_valid, key_held, frame_tick} !== 7'd0) begin
      errors++;
      $display("FAIL reset_out code/valid/held/tick got %0d/%b/%b/%b want 0/0/0/0",
               key_code, key_valid, key_held, frame_tick);
    end
    keys = '0;
    do_reset();
    checks++;
    if (col_out !== 4'b1110) begin
      errors++;
      $display("FAIL scan_col n0 got %b want 1110", col_out);
    end
    for (int n = 1; n <= 2 * FRAME; n++) begin
      @(posedge clk_1kHz); #1;
      exp_col = ~(4'b0001 << ((n / DWELL) % 4));
      checks++;
      if (col_out !== exp_col) begin
        errors++;
        $display("FAIL scan_col n%0d got %b want %b", n, col_out, exp_col);
      end
      if (n == FRAME) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++;
          $display("FAIL scan_tick got %b want 1", frame_tick);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] k;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      k = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      run_frame(k);
      checks++;
      if ({o_tick, o_valid, o_held, o_code} !== {1'b1, m_valid, m_held, m_code} ||
          o_valid !== 1'b0 || o_held !== 1'b0) begin
        errors++;
        $display("FAIL bounce f%0d tick/valid/held/code got %b/%b/%b/%0d want 1/0/0/%0d",
                 f, o_tick, o_valid, o_held, o_code, m_code);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL bounce_mid f%0d stray got %0d want 0", f, stray);
      end
    end
  endtask

  task automatic test_multi();
    logic [15:0] k;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      k = (f < 5) ? 16'h0021 : 16'h0001;
      run_frame(k);
      checks++;
      if ({o_tick, o_valid, o_held, o_code} !== {1'b1, m_valid, m_held, m_code}) begin
        errors++;
        $display("FAIL multi f%0d tick/valid/held/code got %b/%b/%b/%0d want 1/%b/%b/%0d",
                 f, o_tick, o_valid, o_held, o_code, m_valid, m_held, m_code);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL multi_mid f%0d stray got %0d want 0", f, stray);
      end
    end
    checks++;
    if (o_valid !== 1'b1 || o_code !== 4'd0 || o_held !== 1'b1) begin
      errors++;
      $display("FAIL multi_accept valid/code/held got %b/%0d/%b want 1/0/1", o_valid, o_code, o_held);
    end
  endtask

  // Continues from the key-0 press left held by test_multi.
  task automatic test_rerelease();
    logic [15:0] pat [12];
    pat = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
            16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
    for (int f = 0; f < 12; f++) begin
      run_frame(pat[f]);
      checks++;
      if ({o_tick, o_valid, o_held, o_code} !== {1'b1, m_valid, m_held, m_code}) begin
        errors++;
        $display("FAIL rerelease f%0d tick/valid/held/code got %b/%b/%b/%0d want 1/%b/%b/%0d",
                 f, o_tick, o_valid, o_held, o_code, m_valid, m_held, m_code);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL rerelease_mid f%0d stray got %0d want 0", f, stray);
      end
      if (f == 5) begin
        checks++;
        if (o_held !== 1'b0 || o_code !== 4'd0) begin
          errors++;
          $display("FAIL rerelease_drop held/code got %b/%0d want 0/0", o_held, o_code);
        end
      end
      if (f == 8) begin
        checks++;
        if (o_valid !== 1'b1 || o_code !== 4'd15) begin
          errors++;
          $display("FAIL rerelease_k15 valid/code got %b/%0d want 1/15", o_valid, o_code);
        end
      end
    end
  endtask

  task automatic test_reset_in_debounce();
    do_reset();
    for (int f = 0; f < 2; f++) run_frame(16'h0200);
    checks++;
    if (o_valid !== 1'b0 || o_held !== 1'b0) begin
      errors++;
      $display("FAIL deb_pre valid/held got %b/%b want 0/0", o_valid, o_held);
    end
    repeat (3) @(posedge clk_1kHz);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({col_out, key_valid, key_held, frame_tick} !== 7'b1110_000) begin
      errors++;
      $display("FAIL deb_reset col/valid/held/tick got %b/%b/%b/%b want 1110/0/0/0",
               col_out, key_valid, key_held, frame_tick);
    end
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      run_frame(16'h0200);
      checks++;
      if ({o_tick, o_valid, o_held, o_code} !== {1'b1, m_valid, m_held, m_code} ||
          o_valid !== (f == 3)) begin
        errors++;
        $display("FAIL deb_after f%0d tick/valid/held/code got %b/%b/%b/%0d want 1/%b/%b/%0d",
                 f, o_tick, o_valid, o_held, o_code, m_valid, m_held, m_code);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL deb_after_mid f%0d stray got %0d want 0", f, stray);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int r;
    k = '0;
    do_reset();
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r >= 4 && r < 6) k = '0;
      else if (r >= 6 && r < 9) k = 16'(1) << $urandom_range(0, 15);
      else if (r == 9) k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      run_frame(k);
      checks++;
      if ({o_tick, o_valid, o_held, o_code} !== {1'b1, m_valid, m_held, m_code}) begin
        errors++;
        $display("FAIL random f%0d keys %h tick/valid/held/code got %b/%b/%b/%0d want 1/%b/%b/%0d",
                 f, k, o_tick, o_valid, o_held, o_code, m_valid, m_held, m_code);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL random_mid f%0d stray got %0d want 0", f, stray);
      end
    end
  endtask

  initial begin
    model_clear();
    test_single_press();
    test_reset();
    test_bounce();
    test_multi();
    test_rerelease();
    test_reset_in_debounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 key matrix: drives one column low at a time and reads the four row lines back.
- Debounces the result at frame level and emits one pulse and a 4-bit code for each accepted key press.
- It is the input-direction counterpart of the row-scanned dot-matrix driver and runs from the same 1 kHz board clock.
- Its outputs feed the game controller as an alternative to the discrete buttons.

Parameters:
- DWELL, 2: clock cycles each column is driven before its rows are sampled (settling time). Minimum 1.
- DEBOUNCE_FRAMES, 3: number of consecutive identical single-key frames required to accept a press. Minimum 1.
- RELEASE_FRAMES, 3: number of consecutive no-key frames required to accept a release. Minimum 1.

Ports:
- clk_1kHz  in  1  system clock, 1 kHz.
- rst_n  in  1  reset, asynchronous, active-low.
- row_in  in  4  matrix row lines; pulled up externally, so 0 = key pressed.
- col_out  out  4  matrix column drive; active-low, exactly one bit low at any time.
- key_code  out  4  code of the last accepted key, equal to col*4 + row.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high from press acceptance until release acceptance.
- frame_tick  out  1  one-cycle pulse at the end of each full 4-column scan.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - col_out=4'b1110, column index=0, dwell count=0.
  - key_code=0, key_valid=0, key_held=0, frame_tick=0.
  - FSM=IDLE, all frame counters=0.
- Scan timing:
  - The dwell counter runs 0..DWELL-1. row_in is sampled on the edge where the counter equals DWELL-1; on that same edge the column index advances (3 wraps to 0).
  - col_out = ~(1<<col_idx), registered, so it changes on the sample edge.
  - Frame length = 4*DWELL cycles (8 with defaults).
- Frame accumulation:
  - A pressed key at row r in column c has code c*4+r.
  - A per-frame hit count saturates at 2. The frame code is the first hit found, lowest column then lowest row.
  - Frame result is one of NONE (0 hits), SINGLE (1 hit), MULTI (2 or more).
  - The accumulators clear at frame start.
- frame_tick is registered. It is high in the cycle after the column-3 sample edge, which is also when the FSM evaluates the frame.
- FSM, evaluated once per frame:
  - IDLE:
    - SINGLE -> DEBOUNCE; cand=code, dcnt=1.
    - If DEBOUNCE_FRAMES==1, go directly to PRESSED instead (acceptance rules below apply).
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE with code==cand: dcnt++. When dcnt reaches DEBOUNCE_FRAMES -> PRESSED.
    - SINGLE with a different code: restart; cand=new code, dcnt=1.
    - NONE or MULTI -> IDLE.
  - Press acceptance (entry to PRESSED): key_code<=cand; key_valid=1 for exactly one cycle, coincident with frame_tick; key_held<=1.
  - PRESSED:
    - NONE -> RELEASE; rcnt=1. If RELEASE_FRAMES==1, accept the release immediately instead.
    - SINGLE or MULTI (any code): stay. A second key does not re-trigger.
  - RELEASE:
    - NONE: rcnt++. When rcnt reaches RELEASE_FRAMES -> IDLE and key_held<=0.
    - Any hit -> PRESSED with no new key_valid. This is bounce on release.
- key_code holds its value after release until the next accepted press.
- Latency: a key held stably from frame k start is accepted at the end of frame k+DEBOUNCE_FRAMES-1 (cycle 24 after a frame-aligned press, with defaults).
- A press that begins mid-frame is detected from its own column's sample onward. A partial first frame counts as SINGLE only if the key's column sample fell inside the press.
- Counter widths: dcnt and rcnt are sized for their parameter and saturate; they never wrap.

Decomposition:
- Shared package keypad_pkg:
  - FSM state enum {IDLE, DEBOUNCE, PRESSED, RELEASE}.
  - Frame result enum {NONE, SINGLE, MULTI}.
  - KEY_W=4, N_ROW=4, N_COL=4.
- One sub-module, keypad_col_scanner:
  - Contains the dwell counter, column drive, row sampling and per-frame accumulation.
  - Outputs frame_tick, frame result and frame code.
- The top level holds only the FSM and the output registers.

Test Plan:
1. Assert rst_n=0 mid-scan -> in the same cycle col_out=1110 and all outputs 0. After release, col_out sequence is 1110,1110,1101,1101,1011,1011,0111,0111 repeating.
2. Hold row 1 low only while col 2 is driven, for 5 frames from a frame boundary -> exactly one key_valid at cycle 24 with key_code=9; key_held=1 from that cycle.
3. Press code 9 for 1 frame, release 1 frame, repeated 6 times -> key_valid never asserts, key_held stays 0.
4. Press codes 0 and 5 together for 5 frames -> no key_valid. Then release code 5 while keeping code 0 -> key_valid with key_code=0 after 3 further frames.
5. After acceptance, release for 2 frames then press again -> no new key_valid, key_held stays 1. Release for 3 frames -> key_held=0 at the end of frame 3. Press code 15 for 3 frames -> one key_valid with key_code=15.
6. Pull rst_n low during DEBOUNCE (dcnt=2), then release it and keep the key held -> no pulse from the pre-reset count. Acceptance comes 3 full frames after reset.
